// File: rtl/vec_step_counter.sv
// Strided up/down index counter over [0, limit], with wrap or saturate mode.
// Ports: clk; rst (async, active-low); en step enable; load/load_val sync
//   load; up direction; stride step size; limit top of range; sat 1=clamp
//   0=wrap; count registered index; tc registered terminal-count pulse.
module vec_step_counter #(
  parameter int WIDTH    = 10,
  parameter int STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                up,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [WIDTH-1:0]    limit,
  input  logic                sat,
  output logic [WIDTH-1:0]    count,
  output logic                tc
);

  localparam int XW = WIDTH + 1;
  typedef logic [XW-1:0] ext_t;

  ext_t cx, sx, lx, l1x;
  ext_t up_sum, up_rem;
  ext_t dn_dif, dn_gap, dn_rem;
  logic sz, step;
  logic up_in, dn_in;

  logic [WIDTH-1:0] nxt_count;
  logic             nxt_tc;

  // One extra bit so limit+1 and count+stride never overflow.
  assign cx  = {1'b0, count};
  assign sx  = ext_t'(stride);
  assign lx  = {1'b0, limit};
  assign l1x = lx + ext_t'(1);

  assign up_sum = cx + sx;
  assign up_rem = up_sum - l1x;
  assign up_in  = (up_sum <= lx);

  assign dn_in  = (sx <= cx);
  assign dn_dif = cx - sx;
  assign dn_gap = sx - cx;
  assign dn_rem = l1x - dn_gap;

  // A zero stride never moves, even when count sits above limit.
  assign sz   = (stride == '0);
  assign step = en && !load && !sz;

  always_comb begin
    nxt_count = count;
    nxt_tc    = 1'b0;
    unique case (1'b1)
      load: begin
        nxt_count = load_val;
      end
      (!load && !step): begin
        nxt_count = count;
      end
      (step && up): begin
        if (up_in) begin
          nxt_count = up_sum[WIDTH-1:0];
        end else begin
          nxt_tc = 1'b1;
          if (sat)
            nxt_count = limit;
          else if (up_rem <= lx)
            nxt_count = up_rem[WIDTH-1:0];
          else
            nxt_count = '0;
        end
      end
      (step && !up): begin
        if (dn_in) begin
          nxt_count = dn_dif[WIDTH-1:0];
        end else begin
          nxt_tc = 1'b1;
          // Gap beyond a full lap cannot land in range.
          if (sat)
            nxt_count = '0;
          else if (dn_gap <= l1x)
            nxt_count = dn_rem[WIDTH-1:0];
          else
            nxt_count = '0;
        end
      end
      default: begin
        nxt_count = count;
        nxt_tc    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= nxt_count;
      tc    <= nxt_tc;
    end
  end

endmodule

// File: tb/tb_vec_step_counter.sv
// Directed self-checking bench for vec_step_counter.
// Expected values are hand-computed for WIDTH=10, STRIDE_W=4.
module tb_vec_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [9:0] load_val;
  logic       up;
  logic [3:0] stride;
  logic [9:0] limit;
  logic       sat;
  logic [9:0] count;
  logic       tc;

  int checks = 0;
  int errors = 0;

  vec_step_counter #(.WIDTH(10), .STRIDE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_val(load_val), .up(up), .stride(stride),
    .limit(limit), .sat(sat), .count(count), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int ec, input bit et);
    checks++;
    assert (count === 10'(ec) && tc === et) else begin
      errors++;
      $error("FAIL %s count=%0d tc=%0b expected count=%0d tc=%0b",
             tag, count, tc, ec, et);
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = 10'(v);
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; load = 1'b0; load_val = '0;
    up = 1'b1; stride = 4'd3; limit = 10'd9; sat = 1'b0;
    #3;
    chk("rst_async", 0, 0);
    step(); chk("rst_hold1", 0, 0);
    step(); chk("rst_hold2", 0, 0);
    rst = 1'b1;

    step(); chk("upw_3", 3, 0);
    step(); chk("upw_6", 6, 0);
    step(); chk("upw_9", 9, 0);
    step(); chk("upw_2", 2, 1);
    step(); chk("upw_5", 5, 0);
    step(); chk("upw_8", 8, 0);
    step(); chk("upw_1", 1, 1);

    do_load(1); chk("ld_1", 1, 0);
    up = 1'b0;
    step(); chk("dnw_8", 8, 1);
    step(); chk("dnw_5", 5, 0);
    step(); chk("dnw_2", 2, 0);
    step(); chk("dnw_9", 9, 1);

    do_load(0); chk("ld_0", 0, 0);
    up = 1'b1; stride = 4'd4; sat = 1'b1;
    step(); chk("sat_4", 4, 0);
    step(); chk("sat_8", 8, 0);
    step(); chk("sat_9", 9, 1);
    step(); chk("sat_9b", 9, 1);
    up = 1'b0;
    step(); chk("sat_5", 5, 0);
    step(); chk("sat_1", 1, 0);
    step(); chk("sat_0", 0, 1);
    step(); chk("sat_0b", 0, 1);
    en = 1'b0;
    step(); chk("hold_en0", 0, 0);
    en = 1'b1;

    sat = 1'b0; up = 1'b1; stride = 4'd3;
    do_load(700); chk("ld_prio", 700, 0);
    step(); chk("oor_up", 0, 1);
    do_load(700);
    stride = 4'd0;
    step(); chk("stride0", 700, 0);
    up = 1'b0; stride = 4'd3;
    step(); chk("oor_dn", 697, 0);

    up = 1'b1; limit = 10'd1023; stride = 4'd15;
    do_load(1020);
    step(); chk("full_wrap", 11, 1);
    limit = 10'd3; stride = 4'd7;
    do_load(2);
    step(); chk("big_stride", 0, 1);

    limit = 10'd9; stride = 4'd3;
    do_load(8);
    step(); chk("pre_rst", 1, 1);
    #2 rst = 1'b0;
    #1 chk("mid_rst", 0, 0);
    step(); chk("mid_rst_hold", 0, 0);
    rst = 1'b1;
    step(); chk("post_rst", 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_step_counter.md
Name: vec_step_counter

Overview:
- Parametrised successor to the team's basic free-running counter.
- Adds configurable width, run-time stride, up/down direction, programmable limit, and wrap or saturate mode.
- Adds synchronous load and a registered terminal-count pulse.
- Generates element/address indices for vector load/store and lane-loop sequencing in the vector datapath.

Parameters:
- WIDTH, 10, counter and limit width in bits (≥2).
- STRIDE_W, 4, stride width in bits (1..WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  step enable, one step per cycle when high.
- load  input  1  synchronous load of load_val; overrides en.
- load_val  input  WIDTH  value loaded into count.
- up  input  1  1 = count up, 0 = count down.
- stride  input  STRIDE_W  step size, unsigned, zero-extended.
- limit  input  WIDTH  highest legal count value; range is [0, limit].
- sat  input  1  1 = saturate at bound, 0 = wrap modulo (limit+1).
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.

Behaviour:
- Reset:
  - rst low, asynchronously: count=0, tc=0.
  - Outputs hold those values while rst is low.
  - First update happens on the first rising edge with rst high.
- Priority each rising edge: load > en > hold.
  - load=1: count<=load_val, tc<=0, regardless of en, up, limit or sat.
  - load_val > limit is accepted unchanged.
  - en=0 and load=0: count holds, tc<=0.
- Step arithmetic:
  - Done in WIDTH+1 bits.
  - stride and limit are zero-extended.
  - L1 = limit+1, computed in WIDTH+1 bits, so limit=all-ones gives 2^WIDTH.
- Up step:
  - ideal = count+stride.
  - In range when ideal ≤ limit: count<=ideal, tc<=0.
  - Out of range, sat=1: count<=limit, tc<=1.
  - Out of range, sat=0: r = ideal−L1. If r ≤ limit then count<=r, else count<=0. tc<=1.
- Down step:
  - In range when stride ≤ count: count<=count−stride, tc<=0.
  - Out of range, sat=1: count<=0, tc<=1.
  - Out of range, sat=0: r = L1−(stride−count). If r is in [0, limit] then count<=r, else count<=0. tc<=1.
- Count above limit (after load or a limit change):
  - An up step is out of range and resolves by the up rules above.
  - A down step uses the normal down rules, and its result is not re-checked against limit.
- stride=0 with en=1: count holds, tc<=0, even if count > limit.
- Saturate mode at a bound:
  - Every enabled step that would leave the range re-asserts tc.
  - Result: tc stays high for consecutive stepping cycles at the bound.
- Latency and timing:
  - Inputs are sampled on the rising edge; count and tc change on that same edge.
  - tc is high during exactly the cycle in which count shows the wrapped or clamped value.
- Dynamic inputs:
  - up, stride, limit and sat may change on any cycle; each edge uses the values sampled at that edge.
- Reset mid-operation: asynchronous clear as above; no pending state survives.
- Structure: no internal state other than count and tc.

Test Plan:
- Reset: hold rst low 2 cycles while en=1 -> count=0, tc=0 throughout. Release rst -> first step on the next edge.
- Up wrap: limit=9, stride=3, sat=0, up=1, en=1 from 0 -> count 3,6,9,2,5,8,1. tc=1 only in the cycles showing 2 and 1.
- Down wrap: load 1, limit=9, stride=3, up=0 -> count 8 (tc=1), then 5, 2, 9 (tc=1).
- Saturate: limit=9, stride=4, sat=1, up=1 from 0 -> 4, 8, 9 (tc=1), 9 (tc=1). Switch up=0 -> 5 (tc=0), 1, 0 (tc=1).
- Load priority and out-of-range:
  - load=1 with en=1, load_val=700, limit=9 -> count=700, tc=0.
  - Next up step, stride=3, sat=0 -> 703−10=693 > 9, so count=0, tc=1.
  - stride=0 -> count holds, tc=0.
- Edge cases:
  - WIDTH=10, limit=1023, stride=15, from 1020 up, wrap -> 11, tc=1.
  - limit=3, stride=7, from 2 up -> 0, tc=1.
  - Assert rst low mid-sequence between edges -> count=0 immediately, no tc.
